melody_sequencer: RTL and testbench
===================================

Name: melody_sequencer

Overview:
Plays the on-chip melody by stepping the 5-bit note index into the combinational notes ROM at a fixed tempo. It registers the returned divider value toward the downstream tone generator and gates the tone off for rests and for an articulation gap between notes. The block sits between the top-level user inputs (start/stop/loop) and the square-wave tone generator. It supports one-shot and looped playback with a one-cycle done pulse.

Parameters:
BW, 16, width of divider values (ROM output and tone_divider_o)
NOTE_LEN, 6250000, clock cycles per note slot (PLAY + GAP); legal range is NOTE_LEN >= 2
GAP_LEN, 625000, silent cycles at end of each note slot; legal range is 0 <= GAP_LEN < NOTE_LEN
NUM_NOTES, 32, melody length; index wraps after NUM_NOTES-1; legal range is 1..32

Ports:
clk_i  input  1  system clock, single clock domain
rst_n_i  input  1  synchronous reset, active-low
start_i  input  1  level; sampled in IDLE only, begins playback at index 0
stop_i  input  1  level; aborts playback from any state
loop_i  input  1  sampled at end of last note: 1 = restart at index 0, 0 = finish
note_index_o  output  5  address to notes ROM
divider_value_i  input  BW  combinational ROM data for note_index_o; 0 = rest
tone_divider_o  output  BW  registered divider to tone generator
tone_en_o  output  1  registered tone enable
busy_o  output  1  high when state != IDLE
done_o  output  1  one-cycle pulse on natural end of a non-looped melody

Behaviour:
- Reset (rst_n_i=0 at a clk_i edge): state=IDLE, note_index_o=0, duration counter=0, tone_divider_o=0, tone_en_o=0, done_o=0, busy_o=0. Reset overrides all other inputs, including mid-note.
- Duration counter: width $clog2(NOTE_LEN). It counts 0..limit-1 within each of PLAY and GAP and clears on every state change.
- States:
  - IDLE:
    - start_i=1 and stop_i=0: next state PLAY, note_index_o=0, counter=0.
    - stop_i=1 has priority: stay IDLE.
  - PLAY: lasts P = NOTE_LEN-GAP_LEN cycles.
    - At counter==P-1: go to GAP if GAP_LEN>0; otherwise apply the end-of-slot rule directly.
  - GAP: lasts GAP_LEN cycles.
    - At counter==GAP_LEN-1: apply the end-of-slot rule.
  - End-of-slot rule:
    - note_index_o < NUM_NOTES-1: increment note_index_o, go to PLAY.
    - note_index_o == NUM_NOTES-1 and loop_i=1: note_index_o=0, go to PLAY; no done pulse.
    - note_index_o == NUM_NOTES-1 and loop_i=0: go to IDLE, note_index_o=0, done_o=1 for exactly one cycle.
- stop_i=1 in PLAY or GAP:
  - Next edge: IDLE, note_index_o=0, tone_en_o=0, tone_divider_o=0.
  - No done pulse.
  - stop_i wins over a coincident end-of-slot transition.
- start_i while busy is ignored; playback does not restart.
- Output registers, updated every edge:
  - tone_divider_o <= (state==PLAY) ? divider_value_i : 0.
  - tone_en_o <= (state==PLAY) && (divider_value_i != 0).
  - Both outputs therefore lag state and index by one cycle.
- Rests (ROM value 0): tone_en_o stays 0 for the whole slot, and timing is unchanged.
- Consecutive equal notes: the GAP forces tone_en_o low between them so each is re-articulated. With GAP_LEN=0, tone_en_o stays continuously high.
- done_o and the IDLE transition occur on the same edge. busy_o is decoded from the state register.
- Indices in NUM_NOTES..31 are never driven.

Test Plan:
(bench uses NOTE_LEN=8, GAP_LEN=2, NUM_NOTES=32 and a behavioural ROM: idx0=9097, idx1=9097, idx2=0, idx5=11465, others arbitrary)
1. Reset then start_i pulse at edge 0, loop_i=0:
   - note_index_o=0 after edge 0.
   - tone_divider_o=9097 and tone_en_o=1 after edges 1..6; tone_en_o=0 after edges 7..8.
   - note_index_o=1 after edge 8.
   - done_o=1 only after edge 256, with busy_o=0 and note_index_o=0 in the same cycle.
2. Rest slot at idx2 (edges 16..23): tone_en_o=0 and tone_divider_o=0 throughout; note_index_o=3 after edge 24.
3. loop_i=1 held: after edge 256, note_index_o=0, busy_o=1, done_o never asserted; tone_divider_o=9097 after edge 257.
4. stop_i asserted at edge 4, coincident start_i held high:
   - After edge 4: IDLE, busy_o=0, tone_en_o=0, note_index_o=0, no done pulse.
   - With stop_i still high, start_i does not restart playback.
   - After stop_i is released, playback restarts.
5. rst_n_i=0 mid-note (index 5, tone active): all outputs reach reset values on that edge; start_i in the same cycle is ignored.
6. GAP_LEN=0 variant: idx0→idx1 (both 9097) gives tone_en_o continuously high across edges 1..16; note_index_o advances every 8 cycles.

Source files
------------

// File: rtl/melody_sequencer.sv
// melody_sequencer: steps the notes ROM at a fixed tempo and registers the divider and enable for the tone generator
// Ports: clk_i/rst_n_i clock and sync active-low reset; start_i/stop_i/loop_i playback controls;
// note_index_o/divider_value_i ROM address and data; tone_divider_o/tone_en_o registered tone outputs;
// busy_o high while playing; done_o one-cycle pulse at the natural end of a non-looped melody.
module melody_sequencer #(
  parameter int BW = 16,
  parameter int NOTE_LEN = 6250000,
  parameter int GAP_LEN = 625000,
  parameter int NUM_NOTES = 32
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          loop_i,
  output logic [4:0]    note_index_o,
  input  logic [BW-1:0] divider_value_i,
  output logic [BW-1:0] tone_divider_o,
  output logic          tone_en_o,
  output logic          busy_o,
  output logic          done_o
);
  localparam int CW = $clog2(NOTE_LEN);
  localparam int PLAY_LEN = NOTE_LEN - GAP_LEN;
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic last_note, play_end, slot_end;
  assign last_note = note_index_o == 5'(NUM_NOTES - 1);
  assign play_end = cnt == CW'(PLAY_LEN - 1);
  // with no gap the slot ends straight out of PLAY
  assign slot_end = (state == PLAY && play_end && GAP_LEN == 0) ||
                    (state == GAP && cnt == CW'(GAP_LEN - 1));
  assign busy_o = state != IDLE;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt <= '0;
      note_index_o <= '0;
      tone_divider_o <= '0;
      tone_en_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      // stop silences the outputs on the same edge it returns to IDLE
      tone_divider_o <= (state == PLAY && !stop_i) ? divider_value_i : '0;
      tone_en_o <= state == PLAY && !stop_i && divider_value_i != '0;
      done_o <= 1'b0;
      cnt <= cnt + CW'(1);
      if (stop_i) begin
        state <= IDLE;
        cnt <= '0;
        note_index_o <= '0;
      end else if (state == IDLE) begin
        cnt <= '0;
        note_index_o <= '0;
        if (start_i) state <= PLAY;
      end else if (slot_end) begin
        cnt <= '0;
        if (!last_note) begin
          note_index_o <= note_index_o + 5'd1;
          state <= PLAY;
        end else if (loop_i) begin
          note_index_o <= '0;
          state <= PLAY;
        end else begin
          note_index_o <= '0;
          state <= IDLE;
          done_o <= 1'b1;
        end
      end else if (state == PLAY && play_end) begin
        cnt <= '0;
        state <= GAP;
      end
    end
  end
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: self-checking bench for melody_sequencer with a behavioural notes ROM
module tb_melody_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic start_b = 1'b0, stop_b = 1'b0, loop_b = 1'b0;
  logic [4:0] idx, idx_b;
  logic [15:0] rom_a, rom_b, div, div_b;
  logic en, busy, done, en_b, busy_b, done_b;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [4:0] i);
    case (i)
      5'd0, 5'd1: rom = 16'd9097;
      5'd2: rom = 16'd0;
      5'd5: rom = 16'd11465;
      default: rom = 16'd1000 + 16'(i) * 16'd37;
    endcase
  endfunction

  assign rom_a = rom(idx);
  assign rom_b = rom(idx_b);

  melody_sequencer #(.BW(16), .NOTE_LEN(8), .GAP_LEN(2), .NUM_NOTES(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop), .loop_i(loop),
    .note_index_o(idx), .divider_value_i(rom_a), .tone_divider_o(div),
    .tone_en_o(en), .busy_o(busy), .done_o(done));

  melody_sequencer #(.BW(16), .NOTE_LEN(8), .GAP_LEN(0), .NUM_NOTES(32)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_b), .stop_i(stop_b), .loop_i(loop_b),
    .note_index_o(idx_b), .divider_value_i(rom_b), .tone_divider_o(div_b),
    .tone_en_o(en_b), .busy_o(busy_b), .done_o(done_b));

  typedef struct {
    string name;
    logic [4:0] idx;
    logic [15:0] div;
    logic en, busy, done;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string name;
    logic rst_n, start, stop;
    int cycles;
    logic [4:0] idx;
    logic [15:0] div;
    logic en, busy, done;
  } vec_t;
  vec_t tbl[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic pop_compare();
    exp_t e;
    e = sb.pop_front();
    chk({e.name, ".idx"}, 32'(idx), 32'(e.idx));
    chk({e.name, ".div"}, 32'(div), 32'(e.div));
    chk({e.name, ".en"}, 32'(en), 32'(e.en));
    chk({e.name, ".busy"}, 32'(busy), 32'(e.busy));
    chk({e.name, ".done"}, 32'(done), 32'(e.done));
  endtask

  // expected outputs after edge e of a one-shot run started at edge 0 (8-cycle slots, 6 play + 2 gap)
  function automatic exp_t melody_exp(input int e);
    exp_t x;
    int p;
    x.name = $sformatf("melody_e%0d", e);
    x.idx = (e < 256) ? 5'(e / 8) : 5'd0;
    x.busy = e < 256;
    x.done = e == 256;
    p = (e - 1) % 8;
    x.div = (e >= 1 && e <= 256 && p < 6) ? rom(5'((e - 1) / 8)) : 16'd0;
    x.en = x.div != 16'd0;
    return x;
  endfunction

  initial begin
    logic done_seen;
    tbl[0]  = '{"reset",        1'b0, 1'b0, 1'b0, 2,  5'd0, 16'd0,     1'b0, 1'b0, 1'b0};
    tbl[1]  = '{"start",        1'b1, 1'b1, 1'b0, 1,  5'd0, 16'd0,     1'b0, 1'b1, 1'b0};
    tbl[2]  = '{"play_held",    1'b1, 1'b1, 1'b0, 3,  5'd0, 16'd9097,  1'b1, 1'b1, 1'b0};
    tbl[3]  = '{"stop_edge4",   1'b1, 1'b1, 1'b1, 1,  5'd0, 16'd0,     1'b0, 1'b0, 1'b0};
    tbl[4]  = '{"stop_hold",    1'b1, 1'b1, 1'b1, 3,  5'd0, 16'd0,     1'b0, 1'b0, 1'b0};
    tbl[5]  = '{"restart",      1'b1, 1'b1, 1'b0, 1,  5'd0, 16'd0,     1'b0, 1'b1, 1'b0};
    tbl[6]  = '{"restart_play", 1'b1, 1'b0, 1'b0, 2,  5'd0, 16'd9097,  1'b1, 1'b1, 1'b0};
    tbl[7]  = '{"stop_again",   1'b1, 1'b0, 1'b1, 1,  5'd0, 16'd0,     1'b0, 1'b0, 1'b0};
    tbl[8]  = '{"to_idx5",      1'b1, 1'b1, 1'b0, 1,  5'd0, 16'd0,     1'b0, 1'b1, 1'b0};
    tbl[9]  = '{"idx5_tone",    1'b1, 1'b0, 1'b0, 42, 5'd5, 16'd11465, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{"rst_mid_note", 1'b0, 1'b1, 1'b0, 1,  5'd0, 16'd0,     1'b0, 1'b0, 1'b0};

    // reset state
    repeat (2) step();
    sb.push_back('{"reset_state", 5'd0, 16'd0, 1'b0, 1'b0, 1'b0});
    pop_compare();

    // one-shot melody: tempo, articulation gap, rest at idx2, done pulse at edge 256
    rst_n = 1'b1;
    start = 1'b1;
    for (int e = 0; e <= 258; e++) begin
      sb.push_back(melody_exp(e));
      step();
      if (e == 0) start = 1'b0;
      pop_compare();
    end

    // looped playback wraps without a done pulse
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    loop = 1'b1;
    start = 1'b1;
    done_seen = 1'b0;
    for (int e = 0; e <= 257; e++) begin
      step();
      if (e == 0) start = 1'b0;
      done_seen = done_seen | done;
      if (e == 256) begin
        chk("loop_wrap.idx", 32'(idx), 32'd0);
        chk("loop_wrap.busy", 32'(busy), 32'd1);
      end
      if (e == 257) begin
        chk("loop_wrap.div", 32'(div), 32'd9097);
        chk("loop_wrap.en", 32'(en), 32'd1);
      end
    end
    chk("loop_no_done", 32'(done_seen), 32'd0);
    loop = 1'b0;

    // stop, start-while-stopped, restart, reset mid-note
    for (int i = 0; i < 11; i++) begin
      rst_n = tbl[i].rst_n;
      start = tbl[i].start;
      stop = tbl[i].stop;
      sb.push_back('{tbl[i].name, tbl[i].idx, tbl[i].div, tbl[i].en, tbl[i].busy, tbl[i].done});
      repeat (tbl[i].cycles) step();
      pop_compare();
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (2) step();
    sb.push_back('{"post_reset_idle", 5'd0, 16'd0, 1'b0, 1'b0, 1'b0});
    pop_compare();

    // no-gap variant keeps the tone enabled across equal consecutive notes
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("nogap_busy", 32'(busy_b), 32'd1);
    for (int e = 1; e <= 16; e++) begin
      step();
      chk($sformatf("nogap_en_e%0d", e), 32'(en_b), 32'd1);
      chk($sformatf("nogap_idx_e%0d", e), 32'(idx_b), 32'(e / 8));
    end
    chk("nogap_done", 32'(done_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
